// File: rtl/fft_seq_if.sv
// fft_seq_if
//   Handshake and memory-control bundle between the host/datapath side and
//   the FFT sequencer.
//   master : host side -- drives start/valid, observes sequencer outputs
//   slave  : sequencer side (fft_seq_ctrl)
//   Signals:
//     start, valid            frame request / input sample valid
//     busy, done              frame in progress / one-cycle end-of-frame pulse
//     load_we, load_addr      natural-order sample write to port A
//     rd_en, rd_addr_a/b      butterfly or unload read on both ports
//     wr_en, wr_addr_a/b      butterfly write-back on both ports
//     tw_addr, stage          twiddle index and stage, aligned with rd_en
//     out_valid               result pair valid on the SRAM outputs
interface fft_seq_if #(
    parameter int N_LOG2 = 6
);
    logic              start;
    logic              valid;
    logic              busy;
    logic              load_we;
    logic [N_LOG2-1:0] load_addr;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;
    logic [N_LOG2-2:0] tw_addr;
    logic [3:0]        stage;
    logic              out_valid;
    logic              done;

    modport master (
        output start, valid,
        input  busy, load_we, load_addr, rd_en, rd_addr_a, rd_addr_b,
               wr_en, wr_addr_a, wr_addr_b, tw_addr, stage, out_valid, done
    );

    modport slave (
        input  start, valid,
        output busy, load_we, load_addr, rd_en, rd_addr_a, rd_addr_b,
               wr_en, wr_addr_a, wr_addr_b, tw_addr, stage, out_valid, done
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl
//   Sequencer for an in-place radix-2 DIF FFT built around a dual-port SRAM.
//   Per frame: load N natural-order samples, run log2(N) stages of N/2
//   butterflies, then read the bit-reversed result out two bins per cycle.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous active-high reset, priority over everything
//     bus   fft_seq_if.slave: start/valid in; memory addresses, strobes,
//           twiddle index, stage, out_valid, busy, done out
//   Parameters:
//     N_LOG2  log2 of transform length
//     BF_LAT  cycles from butterfly read issue to result ready for write-back
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start
//   S_LOAD    | writing streamed samples, one per valid cycle
//   S_COMPUTE | issuing butterflies; gap_q marks the BF_LAT-cycle barrier
//   S_UNLOAD  | bit-reversed read-out; gap_q marks the final out_valid cycle
//   S_FIN     | one-cycle done pulse
module fft_seq_ctrl #(
    parameter int N_LOG2 = 6,
    parameter int BF_LAT = 3
) (
    input  logic      clk,
    input  logic      rst,
    fft_seq_if.slave  bus
);
    localparam int KW = N_LOG2 - 1;
    localparam int GW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [N_LOG2-1:0] LOAD_LAST = '1;
    localparam logic [KW-1:0]     K_LAST    = '1;
    localparam logic [3:0]        STG_LAST  = 4'(N_LOG2 - 1);
    localparam logic [GW-1:0]     GAP_INIT  = GW'(BF_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_UNLOAD,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [3:0]        stage_q, stage_d;
    logic              gap_q, gap_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              last_q, last_d;
    logic              ov_q;

    logic              issue;
    logic              unl_rd;
    logic              load_we;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_a, rd_b;
    logic [KW-1:0]     tw;
    logic [3:0]        stage_o;
    logic              done;

    logic [BF_LAT-1:0] pipe_v;
    logic [N_LOG2-1:0] pipe_a [BF_LAT];
    logic [N_LOG2-1:0] pipe_b [BF_LAT];

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = x[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Butterfly addressing: span = 2^sh, sh = N_LOG2-1-stage. The read-A
    // address is k with a zero inserted at bit sh (group*2*span + j), the
    // read-B address sets that bit, and the twiddle is j scaled by 2^stage.
    logic [3:0]        sh;
    logic [N_LOG2-1:0] kk, span, j, hi, bf_a, bf_b;
    logic [KW-1:0]     bf_tw;

    always_comb begin
        sh    = STG_LAST - stage_q;
        kk    = {1'b0, k_q};
        span  = N_LOG2'(1) << sh;
        j     = kk & (span - N_LOG2'(1));
        hi    = kk >> sh;
        bf_a  = (hi << (sh + 4'd1)) | j;
        bf_b  = bf_a | span;
        bf_tw = KW'(j << stage_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        stage_d   = stage_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        last_d    = last_q;
        issue     = 1'b0;
        unl_rd    = 1'b0;
        load_we   = 1'b0;
        rd_en     = 1'b0;
        rd_a      = '0;
        rd_b      = '0;
        tw        = '0;
        stage_o   = '0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    cnt_d     = '0;
                    k_d       = '0;
                    stage_d   = '0;
                    gap_d     = 1'b0;
                    gap_cnt_d = '0;
                    last_d    = 1'b0;
                end
            end

            S_LOAD: begin
                if (bus.valid) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + N_LOG2'(1);
                    if (cnt_q == LOAD_LAST) begin
                        state_d = S_COMPUTE;
                    end
                end
            end

            S_COMPUTE: begin
                stage_o = stage_q;
                if (!gap_q) begin
                    issue = 1'b1;
                    rd_en = 1'b1;
                    rd_a  = bf_a;
                    rd_b  = bf_b;
                    tw    = bf_tw;
                    k_d   = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        gap_d     = 1'b1;
                        gap_cnt_d = GAP_INIT;
                        // the barrier after the final stage doubles as the
                        // write-back drain before read-out
                        if (stage_q == STG_LAST) begin
                            last_d = 1'b1;
                        end else begin
                            stage_d = stage_q + 4'd1;
                        end
                    end
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end else begin
                    gap_d = 1'b0;
                    if (last_q) begin
                        state_d = S_UNLOAD;
                        last_d  = 1'b0;
                        k_d     = '0;
                    end
                end
            end

            S_UNLOAD: begin
                if (!gap_q) begin
                    unl_rd = 1'b1;
                    rd_en  = 1'b1;
                    rd_a   = bitrev({k_q, 1'b0});
                    rd_b   = bitrev({k_q, 1'b1});
                    k_d    = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        gap_d = 1'b1;
                    end
                end else begin
                    gap_d   = 1'b0;
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            stage_q   <= '0;
            gap_q     <= 1'b0;
            gap_cnt_q <= '0;
            last_q    <= 1'b0;
            ov_q      <= 1'b0;
            pipe_v    <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            last_q    <= last_d;
            ov_q      <= unl_rd;
            // only butterfly issues enter the write-back pipe; unload reads
            // must never produce a write
            pipe_v[0] <= issue;
            pipe_a[0] <= issue ? rd_a : '0;
            pipe_b[0] <= issue ? rd_b : '0;
            for (int i = 1; i < BF_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.load_we   = load_we;
    assign bus.load_addr = (state_q == S_LOAD) ? cnt_q : '0;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_addr   = tw;
    assign bus.stage     = stage_o;
    assign bus.wr_en     = pipe_v[BF_LAT-1];
    assign bus.wr_addr_a = pipe_a[BF_LAT-1];
    assign bus.wr_addr_b = pipe_b[BF_LAT-1];
    assign bus.out_valid = ov_q;
    assign bus.done      = done;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
`timescale 1ns/1ps
module tb_fft_seq_ctrl;
    localparam int N_LOG2 = 6;
    localparam int BF_LAT = 3;
    localparam int N      = 64;
    localparam int HALF   = 32;
    localparam int SLEN   = HALF + BF_LAT;
    localparam int MAXC   = 360;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_seq_if #(.N_LOG2(N_LOG2)) bus ();

    fft_seq_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int l_busy [MAXC];
    int l_lwe  [MAXC];
    int l_la   [MAXC];
    int l_rd   [MAXC];
    int l_ra   [MAXC];
    int l_rb   [MAXC];
    int l_tw   [MAXC];
    int l_stg  [MAXC];
    int l_wr   [MAXC];
    int l_wa   [MAXC];
    int l_wb   [MAXC];
    int l_ov   [MAXC];
    int l_done [MAXC];

    int sw_err, sw_cyc, sw_act, sw_exp;

    typedef struct {
        int kind;   // 0 = butterfly issue, 1 = unload read
        int stg;
        int idx;    // k or m
        int ea;
        int eb;
        int etw;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sw_begin();
        sw_err = 0;
    endtask

    task automatic sw_pt(input int c, input int act, input int exp);
        if (act != exp) begin
            if (sw_err == 0) begin
                sw_cyc = c;
                sw_act = act;
                sw_exp = exp;
            end
            sw_err++;
        end
    endtask

    task automatic sw_end(input string name);
        n_cmp++;
        if (sw_err != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bad points, first at cycle %0d got %0d expected %0d",
                     name, sw_err, sw_cyc, sw_act, sw_exp);
        end
    endtask

    function automatic int brev(input int x);
        int r, v;
        r = 0;
        v = x;
        for (int i = 0; i < N_LOG2; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // expected butterfly issue in cycle c when COMPUTE starts at cycle cs
    task automatic bf_model(input int c, input int cs, output int er, output int ea,
                            output int eb, output int etw, output int es);
        int off, k, span, grp, jj;
        er = 0; ea = 0; eb = 0; etw = 0; es = 0;
        if (c >= cs && c < cs + N_LOG2 * SLEN) begin
            off = c - cs;
            es  = off / SLEN;
            k   = off % SLEN;
            if (k < HALF) begin
                span = N >> (es + 1);
                grp  = k / span;
                jj   = k % span;
                er   = 1;
                ea   = grp * 2 * span + jj;
                eb   = ea + span;
                etw  = jj << es;
            end
        end
    endtask

    function automatic int vpat(input int mode, input int c);
        if (mode == 1) return (c == 0 || ((c - 1) % 4) != 3) ? 1 : 0;
        return 1;
    endfunction

    task automatic sample(input int c);
        l_busy[c] = int'(bus.busy);
        l_lwe[c]  = int'(bus.load_we);
        l_la[c]   = int'(bus.load_addr);
        l_rd[c]   = int'(bus.rd_en);
        l_ra[c]   = int'(bus.rd_addr_a);
        l_rb[c]   = int'(bus.rd_addr_b);
        l_tw[c]   = int'(bus.tw_addr);
        l_stg[c]  = int'(bus.stage);
        l_wr[c]   = int'(bus.wr_en);
        l_wa[c]   = int'(bus.wr_addr_a);
        l_wb[c]   = int'(bus.wr_addr_b);
        l_ov[c]   = int'(bus.out_valid);
        l_done[c] = int'(bus.done);
    endtask

    // mode 0: valid always high; mode 1: valid low every 4th LOAD cycle and a
    // stray start in mid-LOAD. abort_at >= 0 asserts rst during that cycle.
    task automatic run_frame(input int mode, input int abort_at);
        for (int c = 0; c < MAXC; c++) begin
            @(posedge clk); #1;
            rst       = (c == abort_at) ? 1'b1 : 1'b0;
            bus.start = (c == 0 || (mode == 1 && c == 20)) ? 1'b1 : 1'b0;
            bus.valid = vpat(mode, c) != 0 ? 1'b1 : 1'b0;
            #1;
            sample(c);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},      int'(bus.busy),      0);
        chk({tag, "_load_we"},   int'(bus.load_we),   0);
        chk({tag, "_load_addr"}, int'(bus.load_addr), 0);
        chk({tag, "_rd_en"},     int'(bus.rd_en),     0);
        chk({tag, "_rd_addr_a"}, int'(bus.rd_addr_a), 0);
        chk({tag, "_rd_addr_b"}, int'(bus.rd_addr_b), 0);
        chk({tag, "_wr_en"},     int'(bus.wr_en),     0);
        chk({tag, "_wr_addr_a"}, int'(bus.wr_addr_a), 0);
        chk({tag, "_wr_addr_b"}, int'(bus.wr_addr_b), 0);
        chk({tag, "_tw_addr"},   int'(bus.tw_addr),   0);
        chk({tag, "_stage"},     int'(bus.stage),     0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_done"},      int'(bus.done),      0);
    endtask

    function automatic int idle_cycle();
        for (int c = 1; c < MAXC; c++) begin
            if (l_busy[c-1] == 1 && l_busy[c] == 0) return c;
        end
        return -1;
    endfunction

    // everything from COMPUTE start onward, given COMPUTE starts at cs
    task automatic check_body(input string tag, input int cs);
        int er, ea, eb, etw, es, u;
        u = cs + N_LOG2 * SLEN;

        sw_begin();
        for (int c = 0; c < MAXC; c++) begin
            bf_model(c, cs, er, ea, eb, etw, es);
            if (c >= u && c < u + HALF) er = 1;
            sw_pt(c, l_rd[c], er);
        end
        sw_end({tag, "_rd_en"});

        sw_begin();
        for (int c = cs; c < u; c++) begin
            bf_model(c, cs, er, ea, eb, etw, es);
            if (er == 1) begin
                sw_pt(c, l_ra[c], ea);
                sw_pt(c, l_rb[c], eb);
            end
        end
        sw_end({tag, "_bf_addr"});

        sw_begin();
        for (int c = cs; c < u; c++) begin
            bf_model(c, cs, er, ea, eb, etw, es);
            if (er == 1) begin
                sw_pt(c, l_tw[c], etw);
                sw_pt(c, l_stg[c], es);
            end
        end
        sw_end({tag, "_tw_stage"});

        sw_begin();
        for (int c = 0; c < MAXC; c++) begin
            bf_model(c - BF_LAT, cs, er, ea, eb, etw, es);
            sw_pt(c, l_wr[c], er);
            if (er == 1) begin
                sw_pt(c, l_wa[c], ea);
                sw_pt(c, l_wb[c], eb);
            end
        end
        sw_end({tag, "_writeback"});

        sw_begin();
        for (int m = 0; m < HALF; m++) begin
            sw_pt(u + m, l_ra[u + m], brev(2 * m));
            sw_pt(u + m, l_rb[u + m], brev(2 * m + 1));
        end
        sw_end({tag, "_unload_addr"});

        sw_begin();
        for (int c = 0; c < MAXC; c++) sw_pt(c, l_ov[c], (c > u && c <= u + HALF) ? 1 : 0);
        sw_end({tag, "_out_valid"});

        sw_begin();
        for (int c = 0; c < MAXC; c++) sw_pt(c, l_done[c], (c == u + HALF + 1) ? 1 : 0);
        sw_end({tag, "_done"});

        sw_begin();
        for (int c = 0; c < MAXC; c++) sw_pt(c, l_busy[c], (c >= 1 && c <= u + HALF + 1) ? 1 : 0);
        sw_end({tag, "_busy"});

        chk({tag, "_frame_len"}, idle_cycle(), u + HALF + 2);
    endtask

    initial begin
        int acc, cs, cyc, ev, ew;

        tv[0]  = '{0, 0,  0,  0, 32,  0};
        tv[1]  = '{0, 0, 31, 31, 63, 31};
        tv[2]  = '{0, 1, 16, 32, 48,  0};
        tv[3]  = '{0, 5,  5, 10, 11,  0};
        tv[4]  = '{0, 2,  9, 17, 25,  4};
        tv[5]  = '{0, 3,  7, 11, 15, 24};
        tv[6]  = '{0, 4, 13, 25, 27, 16};
        tv[7]  = '{0, 0, 20, 20, 52, 20};
        tv[8]  = '{0, 1,  0,  0, 16,  0};
        tv[9]  = '{0, 5, 31, 62, 63,  0};
        tv[10] = '{1, 0,  0,  0, 32,  0};
        tv[11] = '{1, 0,  1, 16, 48,  0};
        tv[12] = '{1, 0, 31, 31, 63,  0};
        tv[13] = '{1, 0,  5, 20, 52,  0};
        tv[14] = '{1, 0, 16,  1, 33,  0};

        // reset, then start while rst is still high
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        #1;
        chk_idle("reset");
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        chk_idle("start_under_rst");

        // frame 1: continuous valid
        run_frame(0, -1);
        chk("f1_busy_c0", l_busy[0], 0);
        chk("f1_busy_c1", l_busy[1], 1);
        chk("f1_load_we_c0", l_lwe[0], 0);
        sw_begin();
        for (int c = 1; c <= N; c++) begin
            sw_pt(c, l_lwe[c], 1);
            sw_pt(c, l_la[c], c - 1);
        end
        sw_end("f1_load_seq");
        chk("f1_load_we_after", l_lwe[N + 1], 0);

        for (int i = 0; i < 15; i++) begin
            if (tv[i].kind == 0) begin
                cyc = 65 + tv[i].stg * SLEN + tv[i].idx;
                chk($sformatf("vec%0d_rd_en", i),  l_rd[cyc],  1);
                chk($sformatf("vec%0d_rd_a", i),   l_ra[cyc],  tv[i].ea);
                chk($sformatf("vec%0d_rd_b", i),   l_rb[cyc],  tv[i].eb);
                chk($sformatf("vec%0d_tw", i),     l_tw[cyc],  tv[i].etw);
                chk($sformatf("vec%0d_stage", i),  l_stg[cyc], tv[i].stg);
                chk($sformatf("vec%0d_wr_en", i),  l_wr[cyc + BF_LAT], 1);
                chk($sformatf("vec%0d_wr_a", i),   l_wa[cyc + BF_LAT], tv[i].ea);
                chk($sformatf("vec%0d_wr_b", i),   l_wb[cyc + BF_LAT], tv[i].eb);
            end else begin
                cyc = 275 + tv[i].idx;
                chk($sformatf("vec%0d_unl_rd_en", i), l_rd[cyc], 1);
                chk($sformatf("vec%0d_unl_a", i),     l_ra[cyc], tv[i].ea);
                chk($sformatf("vec%0d_unl_b", i),     l_rb[cyc], tv[i].eb);
                chk($sformatf("vec%0d_unl_ov", i),    l_ov[cyc + 1], 1);
            end
        end

        // stage-0 to stage-1 barrier: last issue at 96, next issue at 100
        chk("barrier_last_issue", l_ra[96], 31);
        chk("barrier_gap1", l_rd[97], 0);
        chk("barrier_gap2", l_rd[98], 0);
        chk("barrier_gap3", l_rd[99], 0);
        chk("barrier_next_rd", l_rd[100], 1);
        chk("barrier_next_stage", l_stg[100], 1);
        chk("f1_done_c308", l_done[308], 1);
        chk("f1_len", idle_cycle(), 309);
        check_body("f1", 65);

        // frame 2: gapped valid with a stray start in LOAD
        run_frame(1, -1);
        acc = 0;
        cs  = -1;
        sw_begin();
        for (int c = 0; c < MAXC && cs < 0; c++) begin
            ev = (c >= 1 && acc < N && vpat(1, c) == 1) ? 1 : 0;
            sw_pt(c, l_lwe[c], ev);
            if (ev == 1) begin
                sw_pt(c, l_la[c], acc);
                acc++;
                if (acc == N) cs = c + 1;
            end
        end
        sw_end("f2_load_seq");
        chk("f2_compute_start", cs, 86);
        if (cs > 0) begin
            ew = vpat(1, cs);
            chk("f2_65th_valid_driven", ew, 1);
            chk("f2_65th_valid_ignored", l_lwe[cs], 0);
            chk("f2_first_issue", l_rd[cs], 1);
            chk("f2_first_issue_b", l_rb[cs], 32);
            check_body("f2", cs);
        end

        // frame 3: abort during stage 3 with write-backs in flight
        run_frame(0, 180);
        chk("abort_pre_stage", l_stg[180], 3);
        chk("abort_pre_wr_en", l_wr[180], 1);
        chk("abort_busy", l_busy[181], 0);
        chk("abort_rd_en", l_rd[181], 0);
        chk("abort_wr_en", l_wr[181], 0);
        sw_begin();
        for (int c = 181; c < MAXC; c++) begin
            sw_pt(c, l_wr[c], 0);
            sw_pt(c, l_rd[c], 0);
            sw_pt(c, l_busy[c], 0);
        end
        sw_end("abort_stays_idle");

        // frame 4: full frame after the abort
        run_frame(0, -1);
        chk("f4_len", idle_cycle(), 309);
        check_body("f4", 65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
